// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives all four {A,B} input vectors into a two-input gate under test. For
//   each vector it waits SETTLE_CYCLES cycles, then samples the gate output
//   and compares it against the EXPECTED truth table.
//
//   Parameters
//     SETTLE_CYCLES  settle cycles between driving a vector and sampling (0..15)
//     EXPECTED       expected truth table, bit {A,B} = Y (default NAND)
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     start      starts one sweep when sampled in IDLE
//     y_in       output of the gate under test
//     a_out      A stimulus to the gate
//     b_out      B stimulus to the gate
//     busy       high whenever the FSM is not in IDLE
//     done       one-cycle pulse as a sweep completes
//     pass       last completed sweep matched EXPECTED on all four vectors
//     captured   sampled y_in for each vector, indexed by {A,B}
//     mismatch   captured XOR EXPECTED, per vector
//
//   Build option
//     GATE_SWEEP_CONT_EN  when defined, the FSM loops DONE -> DRIVE and keeps
//                         sweeping without start until reset.
//
//   state  | meaning
//   IDLE   | waiting for start
//   DRIVE  | apply vector idx to a_out/b_out, load settle counter
//   SETTLE | wait SETTLE_CYCLES cycles for the gate output to settle
//   SAMPLE | capture y_in for vector idx and compare
//   DONE   | pulse done and update pass
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] mismatch
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     r_state, w_state;
    logic [1:0] r_idx, w_idx;
    logic [3:0] r_cnt, w_cnt;
    logic [1:0] r_ab, w_ab;
    logic       r_pass, w_pass;
    logic [3:0] r_captured, w_captured;
    logic [3:0] r_mismatch, w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_cnt      <= 4'd0;
            r_ab       <= 2'd0;
            r_pass     <= 1'b0;
            r_captured <= 4'd0;
            r_mismatch <= 4'd0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_ab       <= w_ab;
            r_pass     <= w_pass;
            r_captured <= w_captured;
            r_mismatch <= w_mismatch;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_ab       = r_ab;
        w_pass     = r_pass;
        w_captured = r_captured;
        w_mismatch = r_mismatch;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_idx      = 2'd0;
                    w_captured = 4'd0;
                    w_mismatch = 4'd0;
                    w_state    = DRIVE;
                end
            end
            DRIVE: begin
                w_ab  = r_idx;
                w_cnt = SETTLE_LOAD;
                // With no settle time the vector goes straight to sampling.
                w_state = (SETTLE_LOAD == 4'd0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                w_cnt = r_cnt - 4'd1;
                // Leaving on a count of 1 gives exactly SETTLE_CYCLES cycles here.
                if (r_cnt <= 4'd1) begin
                    w_state = SAMPLE;
                end
            end
            SAMPLE: begin
                w_captured[r_idx] = y_in;
                w_mismatch[r_idx] = y_in ^ EXPECTED[r_idx];
                if (r_idx == 2'd3) begin
                    w_state = DONE;
                end else begin
                    w_idx   = r_idx + 2'd1;
                    w_state = DRIVE;
                end
            end
            DONE: begin
                w_pass = (r_mismatch == 4'd0);
`ifdef GATE_SWEEP_CONT_EN
                w_idx      = 2'd0;
                w_captured = 4'd0;
                w_mismatch = 4'd0;
                w_state    = DRIVE;
`else
                w_state = IDLE;
`endif
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign a_out    = r_ab[1];
    assign b_out    = r_ab[0];
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign pass     = r_pass;
    assign captured = r_captured;
    assign mismatch = r_mismatch;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized bench for gate_sweep_checker. Two instances (SETTLE_CYCLES 2 and
// 0) share start/rst and a gate truth table gt. A sweep-level model, counting
// cycles since start was accepted, predicts every output each cycle. Directed
// sweeps with literal expectations pin the model.
module tb_gate_sweep_checker;

    localparam int         S0  = 2;
    localparam int         S1  = 0;
    localparam logic [3:0] EXP = 4'b0111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] gt = 4'b0111;

    logic [1:0] a_o, b_o, busy_o, done_o, pass_o, y_o;
    logic [3:0] cap_o [2];
    logic [3:0] mis_o [2];

    always #5 clk = ~clk;

    assign y_o[0] = gt[{a_o[0], b_o[0]}];
    assign y_o[1] = gt[{a_o[1], b_o[1]}];

    gate_sweep_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_o[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .captured(cap_o[0]), .mismatch(mis_o[0]));

    gate_sweep_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_o[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .captured(cap_o[1]), .mismatch(mis_o[1]));

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Sweep-level model: m_k is the cycle number within the current sweep
    // (cycle 1 follows the accepting edge); the sweep lasts 4*(S+2)+1 cycles.
    bit         m_act  [2];
    int         m_k    [2];
    logic [3:0] m_cap  [2];
    logic [3:0] m_mis  [2];
    logic       m_pass [2];
    logic [1:0] m_hold [2];

    always @(posedge clk or posedge rst) begin
        int p, t, v;
        for (int i = 0; i < 2; i++) begin
            p = settle_of(i) + 2;
            t = 4 * p + 1;
            if (rst) begin
                m_act[i] = 0; m_k[i] = 0; m_cap[i] = 0; m_mis[i] = 0;
                m_pass[i] = 0; m_hold[i] = 0;
            end else if (m_act[i]) begin
                if (m_k[i] % p == 0 && m_k[i] <= 4 * p) begin
                    v = m_k[i] / p - 1;
                    m_cap[i][v] = gt[v];
                    m_mis[i][v] = gt[v] ^ EXP[v];
                end
                if (m_k[i] == t) begin
                    m_pass[i] = (m_mis[i] == 4'd0);
                    m_hold[i] = 2'd3;
`ifdef GATE_SWEEP_CONT_EN
                    m_k[i] = 1; m_cap[i] = 0; m_mis[i] = 0;
`else
                    m_act[i] = 0;
`endif
                end else begin
                    m_k[i]++;
                end
            end else if (start) begin
                m_act[i] = 1; m_k[i] = 1; m_cap[i] = 0; m_mis[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        int p, v, eab;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                p = settle_of(i) + 2;
                if (m_act[i] && m_k[i] >= 2) begin
                    v = (m_k[i] - 2) / p;
                    eab = (v > 3) ? 3 : v;
                end else begin
                    eab = int'(m_hold[i]);
                end
                check($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_act[i]));
                check($sformatf("done%0d", i), int'(done_o[i]),
                      int'(m_act[i] && m_k[i] == 4 * p + 1));
                check($sformatf("ab%0d", i), int'({a_o[i], b_o[i]}), eab);
                check($sformatf("captured%0d", i), int'(cap_o[i]), int'(m_cap[i]));
                check($sformatf("mismatch%0d", i), int'(mis_o[i]), int'(m_mis[i]));
                check($sformatf("pass%0d", i), int'(pass_o[i]), int'(m_pass[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One start pulse; watch up to 40 cycles; optional re-pulses at cycles ra/rb.
    task automatic run_sweep(input logic [3:0] tt, input int ra, input int rb,
                             output int d0, output int d1, output int nd0);
        d0 = 0; d1 = 0; nd0 = 0;
        gt = tt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (d0 == 0) d0 = n;
                nd0++;
            end
            if (done_o[1] && d1 == 0) d1 = n;
            start = (n == ra || n == rb);
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        int d0, d1, nd0;
        tick();
        chk_en = 1'b1;
        check("rst_busy", int'(busy_o[0]), 0);
        check("rst_ab", int'({a_o[0], b_o[0]}), 0);
        check("rst_captured", int'(cap_o[0]), 0);
        check("rst_pass", int'(pass_o[0]), 0);
        rst = 1'b0;
        tick();
        tick();

`ifdef GATE_SWEEP_CONT_EN
        d0 = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_o[0]) begin
                d0++;
                check("cont_done_cycle", n, 17 * d0);
            end
            check("cont_busy", int'(busy_o[0]), 1);
        end
        check("cont_done_count", d0, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`else
        // NAND gate under test
        run_sweep(4'b0111, 0, 0, d0, d1, nd0);
        check("nand_done_cycle_s2", d0, 17);
        check("nand_done_cycle_s0", d1, 9);
        check("nand_done_count", nd0, 1);
        check("nand_captured", int'(cap_o[0]), 7);
        check("nand_mismatch", int'(mis_o[0]), 0);
        check("nand_pass_s2", int'(pass_o[0]), 1);
        check("nand_pass_s0", int'(pass_o[1]), 1);
        check("hold_ab_11", int'({a_o[0], b_o[0]}), 3);

        // NOR gate under test
        run_sweep(4'b0001, 0, 0, d0, d1, nd0);
        check("nor_captured", int'(cap_o[0]), 1);
        check("nor_mismatch", int'(mis_o[0]), 6);
        check("nor_pass", int'(pass_o[0]), 0);

        // start re-pulsed while busy
        run_sweep(4'b0111, 3, 10, d0, d1, nd0);
        check("repulse_done_cycle", d0, 17);
        check("repulse_done_count", nd0, 1);

        // reset in cycle 8 aborts the sweep
        gt = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy_o[0]), 0);
        check("abort_ab", int'({a_o[0], b_o[0]}), 0);
        check("abort_captured", int'(cap_o[0]), 0);
        check("abort_pass", int'(pass_o[0]), 0);
        tick();
        rst = 1'b0;
        nd0 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done_o[0]) nd0++;
        end
        check("abort_no_done", nd0, 0);
        tick();
        run_sweep(4'b0111, 0, 0, d0, d1, nd0);
        check("after_abort_done_cycle", d0, 17);
        check("after_abort_pass", int'(pass_o[0]), 1);
`endif

        // Random phase: random starts, gate tables and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 20) == 0) gt = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 200) == 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
